// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the integer register file.
// Several execution units (ALU, load, mul/div) compete for a single register
// file write port. A round-robin pointer picks one requester per cycle. The
// accepted write is presented to the register file one cycle later. A busy
// scoreboard tracks destination registers that have been reserved at issue and
// not yet written back, so issue can detect read-after-write hazards.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int REG_DEPTH  = 32,
  parameter int NUM_REQ    = 3
) (
  input  logic                            clk_i,
  input  logic                            arst_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  output logic                            wr_en_o,
  output logic [ADDR_WIDTH-1:0]           wr_addr_o,
  output logic [DATA_WIDTH-1:0]           wr_data_o,
  input  logic                            rsv_en_i,
  input  logic [ADDR_WIDTH-1:0]           rsv_addr_i,
  input  logic [ADDR_WIDTH-1:0]           chk_addr_1_i,
  input  logic [ADDR_WIDTH-1:0]           chk_addr_2_i,
  output logic                            busy_1_o,
  output logic                            busy_2_o,
  output logic                            idle_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]      ptr_q;
  logic [PTR_W-1:0]      ptr_d;
  logic [NUM_REQ-1:0]    gnt;
  logic [PTR_W-1:0]      gnt_idx;
  logic                  xfer_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [DATA_WIDTH-1:0] data_p0;
  logic [REG_DEPTH-1:0]  busy_q;
  logic [REG_DEPTH-1:0]  busy_d;
  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [DATA_WIDTH-1:0] data_p1;

  // Round-robin search starting at ptr_q; the first valid requester wins.
  // Grants are suppressed while reset is asserted.
  always_comb begin
    int k;
    k       = 0;
    gnt     = '0;
    gnt_idx = '0;
    xfer_p0 = 1'b0;
    addr_p0 = '0;
    data_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(ptr_q) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!xfer_p0 && req_valid_i[k]) begin
        xfer_p0 = 1'b1;
        gnt[k]  = 1'b1;
        gnt_idx = PTR_W'(k);
        addr_p0 = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        data_p0 = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (arst_i) begin
      gnt     = '0;
      xfer_p0 = 1'b0;
    end
  end

  assign req_ready_o = gnt;

  // Pointer moves just past the winner on a transfer, otherwise holds.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer_p0) begin
      if (gnt_idx == PTR_W'(NUM_REQ - 1)) ptr_d = '0;
      else                                ptr_d = gnt_idx + PTR_W'(1);
    end
  end

  // Scoreboard update: writeback clears, then a new reservation sets, so a
  // same-cycle reservation of the register being written back stays busy.
  // Register 0 is hardwired and never tracked.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < REG_DEPTH; r++) begin
      if (xfer_p0 && (addr_p0 == ADDR_WIDTH'(r))) busy_d[r] = 1'b0;
      if (rsv_en_i && (rsv_addr_i == ADDR_WIDTH'(r))) busy_d[r] = 1'b1;
    end
  end

  // Hazard lookup from registered scoreboard; register 0 always reads free.
  always_comb begin
    busy_1_o = 1'b0;
    busy_2_o = 1'b0;
    for (int r = 1; r < REG_DEPTH; r++) begin
      if (chk_addr_1_i == ADDR_WIDTH'(r)) busy_1_o = busy_q[r];
      if (chk_addr_2_i == ADDR_WIDTH'(r)) busy_2_o = busy_q[r];
    end
  end

  // p0 -> p1: arbitration state, scoreboard and the captured write.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ptr_q   <= '0;
      busy_q  <= '0;
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      ptr_q  <= ptr_d;
      busy_q <= busy_d;
      vld_p1 <= xfer_p0 && (addr_p0 != '0);
      if (xfer_p0) begin
        addr_p1 <= addr_p0;
        data_p1 <= data_p0;
      end
    end
  end

  assign wr_en_o   = vld_p1;
  assign wr_addr_o = addr_p1;
  assign wr_data_o = data_p1;
  assign idle_o    = ~(|busy_q) & ~vld_p1;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset behaviour, round-robin order,
// scoreboard set/clear interplay, address-0 writes and asynchronous reset abort.
module tb_regfile_wb_arbiter;

  logic         clk;
  logic         arst;
  logic [2:0]   valid;
  logic [14:0]  raddr;
  logic [191:0] rdata;
  logic [2:0]   ready;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [63:0]  wr_data;
  logic         rsv_en;
  logic [4:0]   rsv_addr;
  logic [4:0]   chk1;
  logic [4:0]   chk2;
  logic         busy1;
  logic         busy2;
  logic         idle;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter dut (
    .clk_i        (clk),
    .arst_i       (arst),
    .req_valid_i  (valid),
    .req_addr_i   (raddr),
    .req_data_i   (rdata),
    .req_ready_o  (ready),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .rsv_en_i     (rsv_en),
    .rsv_addr_i   (rsv_addr),
    .chk_addr_1_i (chk1),
    .chk_addr_2_i (chk2),
    .busy_1_o     (busy1),
    .busy_2_o     (busy2),
    .idle_o       (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [4:0] a, input logic [63:0] d);
    raddr[k*5 +: 5]   = a;
    rdata[k*64 +: 64] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    arst = 1'b0; valid = '0; raddr = '0; rdata = '0;
    rsv_en = 1'b0; rsv_addr = '0; chk1 = '0; chk2 = '0;
    #1 arst = 1'b1;

    // Reset: requests and a reservation are present but must be ignored.
    valid = 3'b111;
    set_req(0, 5'd5, 64'h55);
    set_req(1, 5'd6, 64'h66);
    set_req(2, 5'd7, 64'h77);
    rsv_en = 1'b1; rsv_addr = 5'd3; chk1 = 5'd3;
    #1;
    chk("rst_ready", ready, 3'b000);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_idle", idle, 1);
    tick(); tick();
    chk("rst_rsv_ignored", busy1, 0);
    arst = 1'b0; rsv_en = 1'b0;
    #1;

    // Round robin over three held requests: 0, 1, 2.
    chk("rr_ready0", ready, 3'b001);
    chk("rr_idle0", idle, 1);
    tick();
    chk("rr_wr_en5", wr_en, 1);
    chk("rr_wr_addr5", wr_addr, 5);
    chk("rr_wr_data5", wr_data, 64'h55);
    chk("rr_ready1", ready, 3'b010);
    chk("rr_idle_busy_write", idle, 0);
    tick();
    chk("rr_wr_addr6", wr_addr, 6);
    chk("rr_wr_data6", wr_data, 64'h66);
    chk("rr_ready2", ready, 3'b100);
    tick();
    chk("rr_wr_addr7", wr_addr, 7);
    chk("rr_wr_data7", wr_data, 64'h77);
    valid = 3'b000;
    #1;
    chk("rr_ready_none", ready, 3'b000);
    tick();
    chk("rr_wr_en_off", wr_en, 0);
    chk("rr_idle_end", idle, 1);

    // Reserve x9, then the load unit writes it back (ptr = 0).
    rsv_en = 1'b1; rsv_addr = 5'd9; chk1 = 5'd9;
    tick();
    rsv_en = 1'b0;
    #1;
    chk("sb_busy9", busy1, 1);
    chk("sb_idle_busy", idle, 0);
    valid = 3'b010;
    set_req(1, 5'd9, 64'hDEAD);
    #1;
    chk("sb_ready_load", ready, 3'b010);
    tick();
    valid = 3'b000;
    chk("sb_wr_en9", wr_en, 1);
    chk("sb_wr_addr9", wr_addr, 9);
    chk("sb_wr_data9", wr_data, 64'hDEAD);
    chk("sb_busy9_clear", busy1, 0);
    tick();
    chk("sb_idle_after", idle, 1);

    // Same-cycle reserve and ALU writeback of x4 (ptr = 2, search 2,0,1).
    valid = 3'b001;
    set_req(0, 5'd4, 64'h44);
    rsv_en = 1'b1; rsv_addr = 5'd4; chk2 = 5'd4;
    #1;
    chk("col_ready_alu", ready, 3'b001);
    tick();
    valid = 3'b000; rsv_en = 1'b0;
    chk("col_wr_en4", wr_en, 1);
    chk("col_wr_addr4", wr_addr, 4);
    chk("col_busy4_kept", busy2, 1);
    tick();
    chk("col_busy4_hold", busy2, 1);
    chk("col_idle_busy", idle, 0);
    // Drain x4 so the scoreboard is empty again (ptr = 1, search 1,2,0).
    valid = 3'b001;
    tick();
    valid = 3'b000;
    chk("col_busy4_clear", busy2, 0);
    tick();
    chk("col_idle_after", idle, 1);

    // Requester 2 writes x0 (ptr = 1): accepted, no write, ptr wraps to 0.
    valid = 3'b100;
    set_req(2, 5'd0, 64'h99);
    #1;
    chk("x0_ready", ready, 3'b100);
    tick();
    valid = 3'b000;
    chk("x0_wr_en", wr_en, 0);
    chk("x0_wr_data_captured", wr_data, 64'h99);
    chk("x0_idle", idle, 1);
    valid = 3'b111;
    #1;
    chk("x0_ptr_wrapped", ready, 3'b001);
    valid = 3'b000;
    #1;

    // Lone load requester granted every cycle (ptr = 0).
    valid = 3'b010;
    set_req(1, 5'd10, 64'hA0);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("solo_ready", ready, 3'b010);
      tick();
      chk("solo_wr_addr", wr_addr, 10);
    end
    // ptr = 2 now: requester 2 goes first, then 0.
    valid = 3'b101;
    set_req(0, 5'd11, 64'hB0);
    set_req(2, 5'd12, 64'hC0);
    #1;
    chk("rr101_first", ready, 3'b100);
    tick();
    valid = 3'b001;
    chk("rr101_wr12", wr_addr, 12);
    #1;
    chk("rr101_second", ready, 3'b001);
    tick();
    valid = 3'b000;
    chk("rr101_wr11", wr_addr, 11);
    chk("rr101_data11", wr_data, 64'hB0);

    // Async reset in the middle of a cycle right after a transfer (ptr = 1).
    rsv_en = 1'b1; rsv_addr = 5'd20; chk1 = 5'd20;
    tick();
    rsv_en = 1'b0;
    valid = 3'b010;
    set_req(1, 5'd21, 64'h21);
    tick();
    chk("ar_wr_en_before", wr_en, 1);
    chk("ar_busy20_before", busy1, 1);
    // Requester 1 is pending again (ptr = 2) when reset hits.
    set_req(1, 5'd22, 64'h22);
    #2;
    arst = 1'b1;
    #1;
    chk("ar_wr_en_now", wr_en, 0);
    chk("ar_wr_addr_now", wr_addr, 0);
    chk("ar_wr_data_now", wr_data, 0);
    chk("ar_busy20_now", busy1, 0);
    chk("ar_ready_now", ready, 3'b000);
    rsv_en = 1'b1; rsv_addr = 5'd22; chk2 = 5'd22;
    tick();
    arst = 1'b0; rsv_en = 1'b0;
    valid = 3'b110;
    set_req(2, 5'd23, 64'h23);
    #1;
    chk("ar_no_write_after", wr_en, 0);
    chk("ar_rsv_ignored", busy2, 0);
    chk("ar_idle", idle, 1);
    chk("ar_search_from0", ready, 3'b010);
    tick();
    valid = 3'b000;
    chk("ar_first_wr_addr", wr_addr, 22);
    chk("ar_first_wr_data", wr_data, 64'h22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
